// File: rtl/pipe_pkg.sv
// Shared types and constants for the ID/EX pipeline-register block.
// Forward-select encoding matches the hazard unit's ISA/ISB/ISD outputs.
package pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_t;

    // MOV R0,R0
    localparam logic [31:0] NOP_INSTR_C = 32'hE1A00000;
    localparam int          CTRL_W_DEF  = 12;

endpackage

// File: rtl/fwd_mux4.sv
// 4:1 operand-forwarding mux: register file or one of three bypass paths.
module fwd_mux4
    import pipe_pkg::*;
#(
    parameter int DW = 32
) (
    input  fwd_sel_t        sel_i,
    input  logic [DW-1:0]   rf_i,
    input  logic [DW-1:0]   ex_i,
    input  logic [DW-1:0]   mem_i,
    input  logic [DW-1:0]   wb_i,
    output logic [DW-1:0]   out_o
);

    always_comb begin
        out_o = rf_i;
        unique case (sel_i)
            FWD_RF:  out_o = rf_i;
            FWD_EX:  out_o = ex_i;
            FWD_MEM: out_o = mem_i;
            FWD_WB:  out_o = wb_i;
        endcase
    end

endmodule

// File: rtl/id_ex_pipe_ctrl.sv
// IF/ID and ID/EX pipeline registers driven by hazard-unit decisions,
// with operand forwarding and saturating stall/flush event counters.
module id_ex_pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int              DW        = 32,
    parameter int              CTRL_W    = CTRL_W_DEF,
    parameter int              CNT_W     = 16,
    parameter logic [DW-1:0]   NOP_INSTR = NOP_INSTR_C
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [DW-1:0]       IF_instr,
    input  logic [DW-1:0]       IF_pc,
    input  logic                IF_ID_ld,
    input  logic                C_Unit_MUX,
    input  logic                FLUSH,
    input  logic [1:0]          ISA,
    input  logic [1:0]          ISB,
    input  logic [1:0]          ISD,
    input  logic [CTRL_W-1:0]   CU_ctrl,
    input  logic [DW-1:0]       PA,
    input  logic [DW-1:0]       PB,
    input  logic [DW-1:0]       PD,
    input  logic [DW-1:0]       EX_fwd,
    input  logic [DW-1:0]       MEM_fwd,
    input  logic [DW-1:0]       WB_fwd,
    output logic [DW-1:0]       ID_instr,
    output logic [DW-1:0]       ID_pc,
    output logic [CTRL_W-1:0]   EX_ctrl,
    output logic [DW-1:0]       EX_A,
    output logic [DW-1:0]       EX_B,
    output logic [DW-1:0]       EX_D,
    output logic [3:0]          EX_rd,
    output logic [DW-1:0]       EX_pc,
    output logic                EX_valid,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt
);

    logic [DW-1:0]     id_instr_q, id_instr_d;
    logic [DW-1:0]     id_pc_q, id_pc_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic [DW-1:0]     ex_a_q, ex_a_d;
    logic [DW-1:0]     ex_b_q, ex_b_d;
    logic [DW-1:0]     ex_d_q, ex_d_d;
    logic [3:0]        ex_rd_q, ex_rd_d;
    logic [DW-1:0]     ex_pc_q, ex_pc_d;
    logic              ex_valid_q, ex_valid_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;

    logic [DW-1:0]     fwd_a, fwd_b, fwd_d;
    logic              ex_load;
    logic              stall_ev;

    fwd_mux4 #(.DW(DW)) u_fwd_a (
        .sel_i (fwd_sel_t'(ISA)),
        .rf_i  (PA),
        .ex_i  (EX_fwd),
        .mem_i (MEM_fwd),
        .wb_i  (WB_fwd),
        .out_o (fwd_a)
    );

    fwd_mux4 #(.DW(DW)) u_fwd_b (
        .sel_i (fwd_sel_t'(ISB)),
        .rf_i  (PB),
        .ex_i  (EX_fwd),
        .mem_i (MEM_fwd),
        .wb_i  (WB_fwd),
        .out_o (fwd_b)
    );

    fwd_mux4 #(.DW(DW)) u_fwd_d (
        .sel_i (fwd_sel_t'(ISD)),
        .rf_i  (PD),
        .ex_i  (EX_fwd),
        .mem_i (MEM_fwd),
        .wb_i  (WB_fwd),
        .out_o (fwd_d)
    );

    // A flush squashes the instruction in ID as well as the one in IF.
    assign ex_load  = C_Unit_MUX & ~FLUSH;
    assign stall_ev = ~IF_ID_ld & ~FLUSH;

    always_comb begin
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        if (FLUSH) begin
            id_instr_d = NOP_INSTR;
            id_pc_d    = IF_pc;
        end else if (IF_ID_ld) begin
            id_instr_d = IF_instr;
            id_pc_d    = IF_pc;
        end
    end

    // Bubble clears ctrl/valid only; operand fields keep their last value.
    always_comb begin
        ex_ctrl_d  = '0;
        ex_valid_d = 1'b0;
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        ex_d_d     = ex_d_q;
        ex_rd_d    = ex_rd_q;
        ex_pc_d    = ex_pc_q;
        if (ex_load) begin
            ex_ctrl_d  = CU_ctrl;
            ex_valid_d = 1'b1;
            ex_a_d     = fwd_a;
            ex_b_d     = fwd_b;
            ex_d_d     = fwd_d;
            ex_rd_d    = id_instr_q[15:12];
            ex_pc_d    = id_pc_q;
        end
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (stall_ev && (stall_q != '1)) stall_d = stall_q + 1'b1;
        if (FLUSH && (flush_q != '1))    flush_d = flush_q + 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            id_instr_q <= NOP_INSTR;
            id_pc_q    <= '0;
            ex_ctrl_q  <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_d_q     <= '0;
            ex_rd_q    <= '0;
            ex_pc_q    <= '0;
            ex_valid_q <= 1'b0;
            stall_q    <= '0;
            flush_q    <= '0;
        end else begin
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            ex_ctrl_q  <= ex_ctrl_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_d_q     <= ex_d_d;
            ex_rd_q    <= ex_rd_d;
            ex_pc_q    <= ex_pc_d;
            ex_valid_q <= ex_valid_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
        end
    end

    assign ID_instr  = id_instr_q;
    assign ID_pc     = id_pc_q;
    assign EX_ctrl   = ex_ctrl_q;
    assign EX_A      = ex_a_q;
    assign EX_B      = ex_b_q;
    assign EX_D      = ex_d_q;
    assign EX_rd     = ex_rd_q;
    assign EX_pc     = ex_pc_q;
    assign EX_valid  = ex_valid_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule
